// File: rtl/pipeline_stage_reg_if.sv
// rtl/pipeline_stage_reg_if.sv - handshake bundle between two pipeline stages
// master drives the upstream side and accepts the downstream head; slave is the register itself.
interface pipeline_stage_reg_if #(
  parameter int DATA_WIDTH = 96,
  parameter int CTRL_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_valid;
  logic                  out_ready;
  logic                  flush;
  logic [1:0]            occupancy;

  modport master (
    output in_data, in_ctrl, in_valid, out_ready, flush,
    input  in_ready, out_data, out_ctrl, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_ctrl, in_valid, out_ready, flush,
    output in_ready, out_data, out_ctrl, out_valid, occupancy
  );
endinterface

// File: rtl/pipeline_stage_reg.sv
// rtl/pipeline_stage_reg.sv - elastic two-entry pipeline register with flush and bubble masking
// Main register drives the outputs; the skid register absorbs one accept while downstream stalls.
module pipeline_stage_reg #(
  parameter int                    DATA_WIDTH     = 96,
  parameter int                    CTRL_WIDTH     = 9,
  parameter logic [CTRL_WIDTH-1:0] CTRL_KILL_MASK = 9'b000100010
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  pipeline_stage_reg_if.slave bus_io
);

  // Encoded so the state value is directly the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;

  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = bus_io.in_valid & in_ready;
  assign out_fire  = out_valid & bus_io.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (bus_io.flush) begin
      // Squash everything held or arriving; main keeps its contents so OUT_DATA stays stable.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_data_d = bus_io.in_data;
            main_ctrl_d = bus_io.in_ctrl;
            state_d     = ST_HALF;
          end
        end
        ST_HALF: begin
          if (in_fire && !out_fire) begin
            skid_data_d = bus_io.in_data;
            skid_ctrl_d = bus_io.in_ctrl;
            state_d     = ST_FULL;
          end else if (in_fire && out_fire) begin
            main_data_d = bus_io.in_data;
            main_ctrl_d = bus_io.in_ctrl;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ST_HALF;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Bubbles must never commit state downstream, so kill-masked bits read zero when empty.
  assign bus_io.out_ctrl  = out_valid ? main_ctrl_q : (main_ctrl_q & ~CTRL_KILL_MASK);
  assign bus_io.out_data  = main_data_q;
  assign bus_io.out_valid = out_valid;
  assign bus_io.in_ready  = in_ready;
  assign bus_io.occupancy = state_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb/tb_pipeline_stage_reg.sv - directed vector table, mid-cycle reset and scoreboard stress
module tb_pipeline_stage_reg;

  localparam int DW = 96;
  localparam int CW = 9;

  typedef struct {
    logic          iv;
    logic [DW-1:0] idat;
    logic [CW-1:0] ictl;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [DW-1:0] edat;
    logic [CW-1:0] ectl;
    logic          erdy;
    logic [1:0]    eocc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipeline_stage_reg_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

  pipeline_stage_reg #(
    .DATA_WIDTH    (DW),
    .CTRL_WIDTH    (CW),
    .CTRL_KILL_MASK(9'b000100010)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] idat, input logic [CW-1:0] ictl,
                              input logic ordy, input logic fl, input logic ev,
                              input logic [DW-1:0] edat, input logic [CW-1:0] ectl,
                              input logic erdy, input logic [1:0] eocc);
    vec_t v;
    v.iv = iv; v.idat = idat; v.ictl = ictl; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.edat = edat; v.ectl = ectl; v.erdy = erdy; v.eocc = eocc;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  vec_t          vecs [23];
  logic [DW-1:0] q_data [$];
  logic [CW-1:0] q_ctrl [$];
  int            seq;

  initial begin
    checks = 0;
    errors = 0;
    seq    = 0;
    rst_n  = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    //              iv  idat    ictl     ordy  fl    ev    edat    ectl     erdy  eocc
    vecs[0]  = mk(1'b1, 96'h1,  9'h101, 1'b1, 1'b0, 1'b1, 96'h1,  9'h101, 1'b1, 2'd1);
    vecs[1]  = mk(1'b1, 96'h2,  9'h102, 1'b1, 1'b0, 1'b1, 96'h2,  9'h102, 1'b1, 2'd1);
    vecs[2]  = mk(1'b1, 96'h3,  9'h103, 1'b1, 1'b0, 1'b1, 96'h3,  9'h103, 1'b1, 2'd1);
    vecs[3]  = mk(1'b1, 96'h4,  9'h023, 1'b1, 1'b0, 1'b1, 96'h4,  9'h023, 1'b1, 2'd1);
    vecs[4]  = mk(1'b0, 96'h0,  9'h000, 1'b1, 1'b0, 1'b0, 96'h4,  9'h001, 1'b1, 2'd0);
    vecs[5]  = mk(1'b1, 96'hA,  9'h0A0, 1'b0, 1'b0, 1'b1, 96'hA,  9'h0A0, 1'b1, 2'd1);
    vecs[6]  = mk(1'b1, 96'hB,  9'h0B0, 1'b0, 1'b0, 1'b1, 96'hA,  9'h0A0, 1'b0, 2'd2);
    vecs[7]  = mk(1'b1, 96'hC,  9'h0C0, 1'b0, 1'b0, 1'b1, 96'hA,  9'h0A0, 1'b0, 2'd2);
    vecs[8]  = mk(1'b0, 96'h0,  9'h000, 1'b1, 1'b0, 1'b1, 96'hB,  9'h0B0, 1'b1, 2'd1);
    vecs[9]  = mk(1'b0, 96'h0,  9'h000, 1'b1, 1'b0, 1'b0, 96'hB,  9'h090, 1'b1, 2'd0);
    vecs[10] = mk(1'b1, 96'h10, 9'h1FF, 1'b0, 1'b0, 1'b1, 96'h10, 9'h1FF, 1'b1, 2'd1);
    vecs[11] = mk(1'b0, 96'h0,  9'h000, 1'b1, 1'b0, 1'b0, 96'h10, 9'h1DD, 1'b1, 2'd0);
    vecs[12] = mk(1'b1, 96'hC,  9'h0AA, 1'b0, 1'b0, 1'b1, 96'hC,  9'h0AA, 1'b1, 2'd1);
    vecs[13] = mk(1'b1, 96'hD,  9'h055, 1'b0, 1'b0, 1'b1, 96'hC,  9'h0AA, 1'b0, 2'd2);
    vecs[14] = mk(1'b1, 96'hE,  9'h1FF, 1'b0, 1'b1, 1'b0, 96'hC,  9'h088, 1'b1, 2'd0);
    vecs[15] = mk(1'b0, 96'h0,  9'h000, 1'b1, 1'b0, 1'b0, 96'hC,  9'h088, 1'b1, 2'd0);
    vecs[16] = mk(1'b1, 96'hF,  9'h022, 1'b1, 1'b0, 1'b1, 96'hF,  9'h022, 1'b1, 2'd1);
    vecs[17] = mk(1'b0, 96'h0,  9'h000, 1'b1, 1'b0, 1'b0, 96'hF,  9'h000, 1'b1, 2'd0);
    vecs[18] = mk(1'b1, 96'h20, 9'h033, 1'b0, 1'b0, 1'b1, 96'h20, 9'h033, 1'b1, 2'd1);
    vecs[19] = mk(1'b1, 96'h21, 9'h1FF, 1'b1, 1'b1, 1'b0, 96'h20, 9'h011, 1'b1, 2'd0);
    vecs[20] = mk(1'b1, 96'h22, 9'h044, 1'b0, 1'b0, 1'b1, 96'h22, 9'h044, 1'b1, 2'd1);
    vecs[21] = mk(1'b1, 96'h23, 9'h1E2, 1'b1, 1'b0, 1'b1, 96'h23, 9'h1E2, 1'b1, 2'd1);
    vecs[22] = mk(1'b0, 96'h0,  9'h000, 1'b1, 1'b0, 1'b0, 96'h23, 9'h1C0, 1'b1, 2'd0);

    #1;
    chk("reset_valid", DW'(bus.out_valid), DW'(1'b0));
    chk("reset_ready", DW'(bus.in_ready),  DW'(1'b1));
    chk("reset_occ",   DW'(bus.occupancy), DW'(2'd0));
    chk("reset_data",  bus.out_data,       '0);
    chk("reset_ctrl",  DW'(bus.out_ctrl),  DW'(9'h000));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].idat, vecs[i].ictl, vecs[i].ordy, vecs[i].fl);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), DW'(bus.out_valid), DW'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i),  bus.out_data,       vecs[i].edat);
      chk($sformatf("vec%0d_ctrl", i),  DW'(bus.out_ctrl),  DW'(vecs[i].ectl));
      chk($sformatf("vec%0d_ready", i), DW'(bus.in_ready),  DW'(vecs[i].erdy));
      chk($sformatf("vec%0d_occ", i),   DW'(bus.occupancy), DW'(vecs[i].eocc));
    end

    // Fill to FULL, then assert reset mid-cycle and expect immediate clearing.
    @(negedge clk);
    drive(1'b1, 96'h77, 9'h1FF, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 96'h78, 9'h1FF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("prereset_occ", DW'(bus.occupancy), DW'(2'd2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", DW'(bus.out_valid), DW'(1'b0));
    chk("midreset_ready", DW'(bus.in_ready),  DW'(1'b1));
    chk("midreset_occ",   DW'(bus.occupancy), DW'(2'd0));
    chk("midreset_data",  bus.out_data,       '0);
    chk("midreset_ctrl",  DW'(bus.out_ctrl),  DW'(9'h000));
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postreset_occ",  DW'(bus.occupancy), DW'(2'd0));
    chk("postreset_data", bus.out_data,       '0);

    // Random stress against a FIFO scoreboard.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic          iv, ordy, fl;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      int            sz;
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 99) < 5);
      d    = {32'($urandom()), 32'($urandom()), 32'(seq)};
      c    = CW'($urandom());
      @(negedge clk);
      drive(iv, d, c, ordy, fl);
      sz = q_data.size();
      if (fl) begin
        q_data.delete();
        q_ctrl.delete();
      end else begin
        if (sz > 0 && ordy) begin
          void'(q_data.pop_front());
          void'(q_ctrl.pop_front());
        end
        if (iv && sz < 2) begin
          q_data.push_back(d);
          q_ctrl.push_back(c);
          seq++;
        end
      end
      @(posedge clk);
      #1;
      chk("rnd_occ",   DW'(bus.occupancy), DW'(q_data.size()));
      chk("rnd_valid", DW'(bus.out_valid), DW'(q_data.size() != 0));
      chk("rnd_ready", DW'(bus.in_ready),  DW'(q_data.size() < 2));
      if (q_data.size() != 0) begin
        chk("rnd_data", bus.out_data,      q_data[0]);
        chk("rnd_ctrl", DW'(bus.out_ctrl), DW'(q_ctrl[0]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
